display_write_queue: RTL and testbench

//  Parametrised successor to the single-cycle display dispatcher. Decodes display opcodes from the
//  CPU issue stage, buffers character writes in a FIFO and drains them to the text buffer under a

---
 rtl/display_write_queue.sv | 140 ++++++++++++++
 tb/tb_display_write_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/display_write_queue.sv
`timescale 1ns/1ps
// display_write_queue
//   Decodes display opcodes from the CPU issue stage. DISPLAY writes are
//   buffered in a FIFO and drained to the text buffer through a one-entry
//   output register under a valid/ready handshake. CLEAR waits for all
//   earlier writes to drain, then blanks every screen cell. The CPU is
//   stalled while the FIFO is full or a clear is in progress.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   inst, inst_valid     issued instruction (opcode in inst[31:26]) and its valid
//   rs, rt               position source (rs) and character source (rt)
//   stall                combinational hold request to the CPU
//   buffer_write_enable  registered write valid to the text buffer
//   position, char_code  registered write position / character
//   buffer_ready         text buffer accepts a write this cycle
//   pending              work outstanding (FIFO, output register or clear)
module display_write_queue #(
  parameter int unsigned          POS_WIDTH    = 12,
  parameter int unsigned          CHAR_WIDTH   = 7,
  parameter int unsigned          ADDR_WIDTH   = 3,
  parameter int unsigned          SCREEN_CELLS = 2400,
  parameter logic [5:0]           OP_DISPLAY   = 6'b001000,
  parameter logic [5:0]           OP_CLEAR     = 6'b001001,
  parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR  = 7'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           inst,
  input  logic                  inst_valid,
  input  logic [31:0]           rs,
  input  logic [31:0]           rt,
  output logic                  stall,
  output logic                  buffer_write_enable,
  output logic [POS_WIDTH-1:0]  position,
  output logic [CHAR_WIDTH-1:0] char_code,
  input  logic                  buffer_ready,
  output logic                  pending
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned EW    = POS_WIDTH + CHAR_WIDTH;

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

  state_t                state, state_nx;
  logic [EW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [POS_WIDTH-1:0]  sweep_cnt;

  logic full, fifo_empty, accept, push, clear_acc;
  logic out_free, load, pop, sweep_last;
  logic unused_bits;

  assign unused_bits = ^{inst[25:0], rs[31:POS_WIDTH], rt[31:CHAR_WIDTH]};

  assign full       = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign stall      = full | (state != IDLE);
  assign accept     = inst_valid & ~stall;
  assign push       = accept & (inst[31:26] == OP_DISPLAY);
  assign clear_acc  = accept & (inst[31:26] == OP_CLEAR);
  // Output register may take a new entry when empty or emptying this cycle.
  assign out_free   = ~buffer_write_enable | buffer_ready;
  assign sweep_last = (sweep_cnt == POS_WIDTH'(SCREEN_CELLS - 1));
  assign pending    = ~fifo_empty | buffer_write_enable | (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        pop  = out_free & ~fifo_empty;
        load = pop;
        if (clear_acc) state_nx = DRAIN;
      end
      DRAIN: begin
        pop  = out_free & ~fifo_empty;
        load = pop;
        // The final queued write is either gone or leaving on this edge.
        if (fifo_empty && out_free) state_nx = SWEEP;
      end
      SWEEP: begin
        load = out_free;
        if (out_free && sweep_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rs[POS_WIDTH-1:0], rt[CHAR_WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                      sweep_cnt <= '0;
    else if (state == SWEEP && load) sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer_write_enable <= 1'b0;
      position            <= '0;
      char_code           <= '0;
    end else if (load) begin
      buffer_write_enable <= 1'b1;
      if (state == SWEEP) begin
        position  <= sweep_cnt;
        char_code <= BLANK_CHAR;
      end else begin
        {position, char_code} <= mem[rd_ptr];
      end
    end else if (buffer_ready) begin
      buffer_write_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_write_queue.sv
`timescale 1ns/1ps
module tb_display_write_queue;

  localparam logic [5:0] OP_DISP = 6'b001000;
  localparam logic [5:0] OP_CLR  = 6'b001001;
  localparam logic [5:0] OP_NOP  = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] rs, rt;
  logic        stall;
  logic        we;
  logic [11:0] position;
  logic [6:0]  char_code;
  logic        buffer_ready;
  logic        pending;

  always #5 clk = ~clk;

  display_write_queue #(
    .POS_WIDTH(12), .CHAR_WIDTH(7), .ADDR_WIDTH(3), .SCREEN_CELLS(2400),
    .OP_DISPLAY(6'b001000), .OP_CLEAR(6'b001001), .BLANK_CHAR(7'h20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
    .rs(rs), .rt(rt), .stall(stall), .buffer_write_enable(we),
    .position(position), .char_code(char_code),
    .buffer_ready(buffer_ready), .pending(pending)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  bit          in_clear = 1'b0;
  logic [18:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfers are sampled at negedge; they complete on the following posedge.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (in_clear && sb.size() > 1) check("stall_in_clear", {31'b0, stall}, 32'd1);
      if (we && buffer_ready) begin
        if (sb.size() == 0) check("unexpected_write", {31'b0, we}, 32'd0);
        else check("wr_data", {13'b0, position, char_code}, {13'b0, sb.pop_front()});
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] r_s, input logic [31:0] r_t);
    inst = {op, 26'h0};
    rs = r_s;
    rt = r_t;
    inst_valid = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!stall) begin
        if (op == OP_DISP) sb.push_back({r_s[11:0], r_t[6:0]});
        else if (op == OP_CLR)
          for (int p = 0; p < 2400; p++) sb.push_back({12'(p), 7'h20});
        n_acc++;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        return;
      end
    end
    check("issue_timeout", {31'b0, stall}, 32'd0);
    inst_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) return;
    end
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          base;
    logic [31:0] snap;
    logic        r;

    rst_n = 1'b0; inst = '0; inst_valid = 1'b0; rs = '0; rt = '0; buffer_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_we",      {31'b0, we}, 32'd0);
    check("rst_pos",     {20'b0, position}, 32'd0);
    check("rst_char",    {25'b0, char_code}, 32'd0);
    check("rst_stall",   {31'b0, stall}, 32'd0);
    check("rst_pending", {31'b0, pending}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // 1: latency of a single write
    issue(OP_DISP, 32'h123, 32'h41);
    #1;
    check("t1_we_n1", {31'b0, we}, 32'd0);
    @(posedge clk); #2;
    check("t1_we_n2",   {31'b0, we}, 32'd1);
    check("t1_pos_n2",  {20'b0, position}, 32'h123);
    check("t1_char_n2", {25'b0, char_code}, 32'h41);
    @(posedge clk); #2;
    check("t1_we_n3", {31'b0, we}, 32'd0);

    // 2: fill to capacity with the text buffer blocked
    buffer_ready = 1'b0;
    base = n_acc;
    fork
      for (int i = 0; i < 10; i++) issue(OP_DISP, 32'h200 + i, 32'h30 + i);
      begin
        for (int c = 0; c < 100; c++) begin
          @(posedge clk); #2;
          if (n_acc == base + 9) break;
        end
        repeat (3) begin
          @(posedge clk); #2;
          check("t2_stall", {31'b0, stall}, 32'd1);
          check("t2_held",  n_acc, base + 9);
        end
        buffer_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
          check("t2_stream_we", {31'b0, we}, 32'd1);
          @(posedge clk); #2;
        end
      end
    join
    wait_drain(100);
    check("t2_pending", {31'b0, pending}, 32'd0);

    // 3: backpressure toggling during a burst
    buffer_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(OP_DISP, 32'h300 + i, 32'h50 + i);
    for (int k = 0; k < 8; k++) begin
      buffer_ready = (k % 2 == 0);
      r = buffer_ready;
      snap = {12'b0, we, position, char_code};
      @(posedge clk); #2;
      if (!r) check("t3_hold", {12'b0, we, position, char_code}, snap);
    end
    buffer_ready = 1'b1;
    wait_drain(100);
    check("t3_pending", {31'b0, pending}, 32'd0);

    // 4: CLEAR behind pending writes
    buffer_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(OP_DISP, 32'h400 + i, 32'h61 + i);
    issue(OP_CLR, 32'h0, 32'h0);
    in_clear = 1'b1;
    check("t4_stall_after_clear", {31'b0, stall}, 32'd1);
    buffer_ready = 1'b1;
    wait_drain(3000);
    in_clear = 1'b0;
    check("t4_stall_end",   {31'b0, stall}, 32'd0);
    check("t4_pending_end", {31'b0, pending}, 32'd0);

    // 5: reset in the middle of a sweep
    issue(OP_CLR, 32'h0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (we && position == 12'd1000) break;
    end
    check("t5_reached", {20'b0, position}, 32'd1000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    #1;
    check("t5_we",      {31'b0, we}, 32'd0);
    check("t5_stall",   {31'b0, stall}, 32'd0);
    check("t5_pending", {31'b0, pending}, 32'd0);
    repeat (50) @(posedge clk);
    #2;
    check("t5_quiet", {31'b0, we}, 32'd0);

    // 6: ignored opcode, and DISPLAY without inst_valid
    inst = {OP_NOP, 26'h0}; rs = 32'h55; rt = 32'h42; inst_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      check("t6_nop_stall", {31'b0, stall}, 32'd0);
    end
    inst = {OP_DISP, 26'h0}; inst_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      check("t6_inv_pending", {31'b0, pending}, 32'd0);
    end
    repeat (3) begin
      @(posedge clk); #2;
      check("t6_we",    {31'b0, we}, 32'd0);
      check("t6_stall", {31'b0, stall}, 32'd0);
    end
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
